que_slot_scheduler: RTL and testbench
=====================================

# que_slot_scheduler

Sequences a bank of SLOT_COUNT receive packet slots between one ingress byte stream and one egress byte stream. On ingress it claims a free slot per packet, steers bytes and the good/bad verdict to that slot, and drops packets when no slot is free. On egress it round-robin arbitrates among slots holding complete good packets and drains one packet at a time to the transmit side. It sits between the per-port CRC/frame checker and the switch fabric output.

## Interface

- SLOT_COUNT, 4: number of slots managed, 2..16.
- clock  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  ingress byte.
- rx_data_enable  input  1  rx_data valid this cycle.
- rx_good_packet  input  1  one-cycle pulse: current packet passed the check.
- rx_bad_packet  input  1  one-cycle pulse: current packet failed the check.
- slot_ready  input  SLOT_COUNT  per-slot idle/accepting flag from the slots.
- slot_data_ready  input  SLOT_COUNT  per-slot holding a good packet.
- slot_push_data  input  8*SLOT_COUNT  per-slot read byte; slot i at bits [8i+7:8i].
- slot_push_data_valid  input  SLOT_COUNT  per-slot read byte valid.
- slot_data  output  8  rx_data fanned out to all slots.
- slot_data_enable  output  SLOT_COUNT  one-hot write enable.
- slot_good_packet  output  SLOT_COUNT  one-hot good verdict.
- slot_bad_packet  output  SLOT_COUNT  one-hot bad verdict.
- slot_push_data_enable  output  SLOT_COUNT  one-hot read enable.
- tx_data  output  8  egress byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  downstream accepts the byte this cycle.
- tx_packet_done  output  1  one-cycle pulse after a packet is fully drained.
- drop_count  output  16  saturating count of packets dropped for lack of a slot.

## Operation

- busy mask (SLOT_COUNT bits, reset 0): set when a slot is claimed, cleared when it is drained or receives bad_packet. Free slot = slot_ready[i] & ~busy[i].
- Ingress FSM states I_IDLE, I_WRITE, I_DROP; wr_slot register.
- I_IDLE, rx_data_enable=1: if any free slot, the lowest-index free slot becomes wr_slot; slot_data_enable[wr_slot]=1 that same cycle; busy set; -> I_WRITE. If no free slot: drop_count+1 (saturating at 0xFFFF); -> I_DROP.
- I_WRITE: slot_data_enable[wr_slot]=rx_data_enable. rx_bad_packet -> slot_bad_packet[wr_slot]=1, busy[wr_slot] cleared, -> I_IDLE. rx_good_packet without bad -> slot_good_packet[wr_slot]=1, -> I_IDLE. Both asserted at once: bad wins, good is not forwarded.
- I_DROP: no slot outputs asserted; rx_good_packet or rx_bad_packet -> I_IDLE.
- Verdict in I_IDLE (no packet open): ignored.
- Egress FSM states E_IDLE, E_DRAIN; grant and last_grant registers.
- E_IDLE: candidates = slot_data_ready & busy. Search from last_grant+1 upward, wrapping; first candidate -> grant, last_grant=grant, -> E_DRAIN.
- E_DRAIN: tx_data = slot_push_data[grant]; tx_valid = slot_push_data_valid[grant]; slot_push_data_enable[grant] = tx_valid & tx_ready. When slot_data_ready[grant]=0: busy[grant] cleared, tx_packet_done pulse, -> E_IDLE.
- A slot being written is never a drain candidate, because slot_data_ready only rises after its good verdict.

## Timing

- Reset values: all outputs 0, both FSMs idle, busy=0, drop_count=0, last_grant=SLOT_COUNT-1, so the first grant goes to slot 0.
- The slot_* ingress outputs are combinational from rx_* and the FSM state, with zero latency. The first byte of a packet is written in the cycle it arrives.
- Egress: candidate visible in E_IDLE -> grant registered -> tx_valid is possible the next cycle, a 1-cycle arbitration latency.
- tx_data and tx_valid are combinational from the granted slot. Transfer occurs when tx_valid & tx_ready. tx_valid may fall while the slot's FIFO refills, and the bench must tolerate this.
- tx_packet_done is registered and asserts the cycle after the E_DRAIN exit is detected. The back-to-back minimum gap between packets is 1 cycle in E_IDLE.
- Ingress and egress run concurrently. A slot may be claimed in the same cycle another slot is being drained.
- An asynchronous reset mid-packet aborts both FSMs immediately. Slots share reset_n and are flushed by their own logic.

## Test plan

- Single packet: 5 bytes 0x11..0x15 then good, tx_ready=1 -> slot 0 written; tx emits 0x11..0x15; tx_packet_done pulses once; busy=0 afterwards.
- Fill and drop: 4 good packets with tx_ready=0 fill slots 0..3 in order. A 5th packet -> slot_data_enable stays 0; drop_count=1; the following packet is also dropped (drop_count=2).
- Bad packet: bytes then rx_bad_packet -> slot_bad_packet[0] pulses; no tx output; the next packet is claimed by slot 0 again.
- Round robin: slots 0, 1, 2 hold packets A, B, C, then tx_ready=1 -> drained in order A, B, C. Refill slot 0 while C drains -> slot 0 is drained next.
- Simultaneous good and bad on one packet -> only slot_bad_packet is asserted; nothing is transmitted.
- Backpressure: tx_ready toggling 1/0 every cycle on an 8-byte packet -> all 8 bytes are delivered in order with no duplicates; slot_push_data_enable is asserted only when tx_ready=1.

Source files
------------

// File: rtl/que_slot_scheduler.sv
// Slot sequencer between one ingress byte stream and a bank of packet slots,
// with round-robin draining of completed good packets to one egress stream.
module que_slot_scheduler #(
  parameter int SLOT_COUNT = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_enable,
  input  logic                    rx_good_packet,
  input  logic                    rx_bad_packet,
  input  logic [SLOT_COUNT-1:0]   slot_ready,
  input  logic [SLOT_COUNT-1:0]   slot_data_ready,
  input  logic [8*SLOT_COUNT-1:0] slot_push_data,
  input  logic [SLOT_COUNT-1:0]   slot_push_data_valid,
  output logic [7:0]              slot_data,
  output logic [SLOT_COUNT-1:0]   slot_data_enable,
  output logic [SLOT_COUNT-1:0]   slot_good_packet,
  output logic [SLOT_COUNT-1:0]   slot_bad_packet,
  output logic [SLOT_COUNT-1:0]   slot_push_data_enable,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_packet_done,
  output logic [15:0]             drop_count
);

  localparam int IDX_W = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

  typedef enum logic [1:0] {I_IDLE, I_WRITE, I_DROP} ing_state_t;
  typedef enum logic       {E_IDLE, E_DRAIN}         egr_state_t;

  ing_state_t            ing_state_reg, ing_state_next;
  egr_state_t            egr_state_reg, egr_state_next;
  logic [IDX_W-1:0]      wr_slot_reg, wr_slot_next;
  logic [IDX_W-1:0]      grant_reg, grant_next;
  logic [IDX_W-1:0]      last_grant_reg, last_grant_next;
  logic [SLOT_COUNT-1:0] busy_reg, busy_next;
  logic [15:0]           drop_count_reg;
  logic                  done_reg, done_next;

  logic [SLOT_COUNT-1:0] free_mask;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic [SLOT_COUNT-1:0] cand_mask;
  logic                  cand_found;
  logic [IDX_W-1:0]      cand_idx;
  logic [SLOT_COUNT-1:0] claim_mask, bad_release, drain_release;
  logic                  drop_inc;
  logic [7:0]            grant_byte;

  assign free_mask = slot_ready & ~busy_reg;
  assign cand_mask = slot_data_ready & busy_reg;
  assign slot_data = rx_data;

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Round-robin search starting just after the previous grant.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = 1; k <= SLOT_COUNT; k++) begin
      int idx;
      idx = (int'(last_grant_reg) + k) % SLOT_COUNT;
      if (!cand_found && cand_mask[IDX_W'(idx)]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    grant_byte = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (grant_reg == IDX_W'(i)) grant_byte = slot_push_data[8*i +: 8];
    end
  end

  // Ingress: claim, steer and close out one packet at a time.
  always_comb begin
    ing_state_next   = ing_state_reg;
    wr_slot_next     = wr_slot_reg;
    claim_mask       = '0;
    bad_release      = '0;
    drop_inc         = 1'b0;
    slot_data_enable = '0;
    slot_good_packet = '0;
    slot_bad_packet  = '0;
    case (ing_state_reg)
      I_IDLE: begin
        if (rx_data_enable) begin
          if (free_found) begin
            wr_slot_next               = free_idx;
            slot_data_enable[free_idx] = 1'b1;
            claim_mask[free_idx]       = 1'b1;
            ing_state_next             = I_WRITE;
          end else begin
            drop_inc       = 1'b1;
            ing_state_next = I_DROP;
          end
        end
      end
      I_WRITE: begin
        slot_data_enable[wr_slot_reg] = rx_data_enable;
        if (rx_bad_packet) begin
          slot_bad_packet[wr_slot_reg] = 1'b1;
          bad_release[wr_slot_reg]     = 1'b1;
          ing_state_next               = I_IDLE;
        end else if (rx_good_packet) begin
          slot_good_packet[wr_slot_reg] = 1'b1;
          ing_state_next                = I_IDLE;
        end
      end
      I_DROP: begin
        if (rx_good_packet || rx_bad_packet) ing_state_next = I_IDLE;
      end
      default: ing_state_next = I_IDLE;
    endcase
  end

  // Egress: arbitrate in E_IDLE, stream the granted slot in E_DRAIN.
  always_comb begin
    egr_state_next        = egr_state_reg;
    grant_next            = grant_reg;
    last_grant_next       = last_grant_reg;
    drain_release         = '0;
    done_next             = 1'b0;
    tx_data               = '0;
    tx_valid              = 1'b0;
    slot_push_data_enable = '0;
    case (egr_state_reg)
      E_IDLE: begin
        if (cand_found) begin
          grant_next      = cand_idx;
          last_grant_next = cand_idx;
          egr_state_next  = E_DRAIN;
        end
      end
      E_DRAIN: begin
        tx_data                          = grant_byte;
        tx_valid                         = slot_push_data_valid[grant_reg];
        slot_push_data_enable[grant_reg] = tx_valid & tx_ready;
        if (!slot_data_ready[grant_reg]) begin
          drain_release[grant_reg] = 1'b1;
          done_next                = 1'b1;
          egr_state_next           = E_IDLE;
        end
      end
      default: egr_state_next = E_IDLE;
    endcase
  end

  // A claimed slot is never busy and a drained slot always is, so the
  // set and clear terms never collide on the same bit.
  assign busy_next = (busy_reg & ~bad_release & ~drain_release) | claim_mask;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ing_state_reg  <= I_IDLE;
      egr_state_reg  <= E_IDLE;
      wr_slot_reg    <= '0;
      grant_reg      <= '0;
      last_grant_reg <= IDX_W'(SLOT_COUNT - 1);
      busy_reg       <= '0;
      drop_count_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      ing_state_reg  <= ing_state_next;
      egr_state_reg  <= egr_state_next;
      wr_slot_reg    <= wr_slot_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      if (drop_inc && (drop_count_reg != 16'hFFFF)) drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign tx_packet_done = done_reg;
  assign drop_count     = drop_count_reg;

endmodule

// File: tb/tb_que_slot_scheduler.sv
// Directed bench for que_slot_scheduler with a behavioural model of four
// packet slots and a byte/packet monitor on the transmit side.
module tb_que_slot_scheduler;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rx_data_enable = 1'b0;
  logic           rx_good_packet = 1'b0;
  logic           rx_bad_packet = 1'b0;
  logic           tx_ready = 1'b0;
  wire  [N-1:0]   slot_ready, slot_data_ready, slot_push_data_valid;
  wire  [8*N-1:0] slot_push_data;
  logic [7:0]     slot_data, tx_data;
  logic [N-1:0]   slot_data_enable, slot_good_packet, slot_bad_packet, slot_push_data_enable;
  logic           tx_valid, tx_packet_done;
  logic [15:0]    drop_count;

  int vec_count = 0;
  int miscompare = 0;
  int done_count = 0;
  int pe_viol = 0;
  bit bp_mode = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  que_slot_scheduler #(.SLOT_COUNT(N)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_data(rx_data), .rx_data_enable(rx_data_enable),
    .rx_good_packet(rx_good_packet), .rx_bad_packet(rx_bad_packet),
    .slot_ready(slot_ready), .slot_data_ready(slot_data_ready),
    .slot_push_data(slot_push_data), .slot_push_data_valid(slot_push_data_valid),
    .slot_data(slot_data), .slot_data_enable(slot_data_enable),
    .slot_good_packet(slot_good_packet), .slot_bad_packet(slot_bad_packet),
    .slot_push_data_enable(slot_push_data_enable),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_packet_done(tx_packet_done), .drop_count(drop_count)
  );

  // Slot model: a write FIFO that becomes readable after a good verdict
  // and returns to ready once its last byte has been popped.
  logic [7:0] mem [N][64];
  logic [5:0] wptr [N];
  logic [5:0] rptr [N];
  logic [N-1:0] complete;

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign slot_ready[gi]           = !complete[gi] && (wptr[gi] == rptr[gi]);
    assign slot_data_ready[gi]      = complete[gi] && (wptr[gi] != rptr[gi]);
    assign slot_push_data_valid[gi] = complete[gi] && (wptr[gi] != rptr[gi]);
    assign slot_push_data[8*gi +: 8] = mem[gi][rptr[gi]];
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
      complete <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (slot_bad_packet[i]) begin
          wptr[i]     <= '0;
          rptr[i]     <= '0;
          complete[i] <= 1'b0;
        end else begin
          if (slot_data_enable[i]) begin
            mem[i][wptr[i]] <= slot_data;
            wptr[i]         <= wptr[i] + 6'd1;
          end
          if (slot_good_packet[i]) complete[i] <= 1'b1;
          if (slot_push_data_enable[i]) begin
            if (rptr[i] + 6'd1 == wptr[i]) begin
              wptr[i]     <= '0;
              rptr[i]     <= '0;
              complete[i] <= 1'b0;
            end else begin
              rptr[i] <= rptr[i] + 6'd1;
            end
          end
        end
      end
    end
  end

  always @(posedge clock) begin
    if (reset_n) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (tx_packet_done) done_count++;
      if ((|slot_push_data_enable) && !tx_ready) pe_viol++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vec_count++;
    if (got !== expv) begin
      miscompare++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
    if (bp_mode) tx_ready = ~tx_ready;
  endtask

  // verdict: 0 good, 1 bad, 2 both; exp_slot is the one-hot slot expected
  // to take the packet (zero when it should be dropped).
  task automatic send_pkt(input string tag, input int n, input logic [7:0] base,
                          input int verdict, input logic [N-1:0] exp_slot);
    logic [N-1:0] first_sde, any_sde, good_m, bad_m;
    first_sde = '0;
    any_sde   = '0;
    for (int k = 0; k < n; k++) begin
      next_cycle();
      rx_data        = base + 8'(k);
      rx_data_enable = 1'b1;
      #1;
      if (k == 0) first_sde = slot_data_enable;
      any_sde |= slot_data_enable;
    end
    next_cycle();
    rx_data        = '0;
    rx_data_enable = 1'b0;
    rx_good_packet = (verdict != 1);
    rx_bad_packet  = (verdict != 0);
    #1;
    good_m = slot_good_packet;
    bad_m  = slot_bad_packet;
    next_cycle();
    rx_good_packet = 1'b0;
    rx_bad_packet  = 1'b0;
    check_val({tag, "_first_sde"}, 32'(first_sde), 32'(exp_slot));
    check_val({tag, "_all_sde"}, 32'(any_sde), 32'(exp_slot));
    check_val({tag, "_good"}, 32'(good_m), (verdict == 0) ? 32'(exp_slot) : 32'd0);
    check_val({tag, "_bad"}, 32'(bad_m), (verdict != 0) ? 32'(exp_slot) : 32'd0);
    if (verdict == 0 && exp_slot != '0)
      for (int k = 0; k < n; k++) exp_q.push_back(base + 8'(k));
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int c;
    c = 0;
    while (done_count < target && c < budget) begin
      next_cycle();
      c++;
    end
    check_val({tag, "_done"}, 32'(done_count), 32'(target));
  endtask

  task automatic compare_rx(input string tag);
    check_val({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) check_val($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) next_cycle();
    #1;
    check_val("rst_drop_count", 32'(drop_count), 32'd0);
    check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_tx_done", 32'(tx_packet_done), 32'd0);
    check_val("rst_sde", 32'(slot_data_enable), 32'd0);
    check_val("rst_push_en", 32'(slot_push_data_enable), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Single packet straight through.
    tx_ready = 1'b1;
    send_pkt("single", 5, 8'h11, 0, 4'b0001);
    wait_done("single", 1, 60);
    compare_rx("single");
    repeat (5) next_cycle();
    check_val("single_once", 32'(done_count), 32'd1);

    // Fill all slots with egress stalled, then two drops.
    tx_ready = 1'b0;
    send_pkt("fill0", 3, 8'h20, 0, 4'b0001);
    send_pkt("fill1", 3, 8'h30, 0, 4'b0010);
    send_pkt("fill2", 3, 8'h40, 0, 4'b0100);
    send_pkt("fill3", 3, 8'h50, 0, 4'b1000);
    send_pkt("drop1", 3, 8'hE0, 0, 4'b0000);
    check_val("drop_count1", 32'(drop_count), 32'd1);
    send_pkt("drop2", 2, 8'hF0, 0, 4'b0000);
    check_val("drop_count2", 32'(drop_count), 32'd2);
    check_val("stalled_rx", 32'(rx_q.size()), 32'd0);
    tx_ready = 1'b1;
    wait_done("fill", 5, 200);
    compare_rx("fill");

    // Bad packet frees slot 0 with nothing transmitted.
    send_pkt("bad", 4, 8'h60, 1, 4'b0001);
    repeat (10) next_cycle();
    check_val("bad_no_tx", 32'(rx_q.size()), 32'd0);
    check_val("bad_no_done", 32'(done_count), 32'd5);
    send_pkt("after_bad", 3, 8'h70, 0, 4'b0001);
    wait_done("after_bad", 6, 60);
    compare_rx("after_bad");

    // Good and bad together: bad wins.
    send_pkt("both", 3, 8'h78, 2, 4'b0001);
    repeat (10) next_cycle();
    check_val("both_no_tx", 32'(rx_q.size()), 32'd0);
    check_val("both_no_done", 32'(done_count), 32'd6);

    // Round robin: after B (slot 1) both C (slot 2) and the refill D
    // (slot 0) are ready; C must go first.
    tx_ready = 1'b0;
    send_pkt("rr_a", 4, 8'h80, 0, 4'b0001);
    send_pkt("rr_b", 8, 8'h90, 0, 4'b0010);
    send_pkt("rr_c", 3, 8'hA0, 0, 4'b0100);
    tx_ready = 1'b1;
    wait_done("rr_a", 7, 60);
    send_pkt("rr_d", 1, 8'hB0, 0, 4'b0001);
    wait_done("rr_all", 10, 300);
    compare_rx("rr");

    // Backpressure with tx_ready toggling every cycle.
    bp_mode = 1'b1;
    send_pkt("bp", 8, 8'hC0, 0, 4'b0001);
    wait_done("bp", 11, 400);
    bp_mode = 1'b0;
    compare_rx("bp");
    check_val("bp_push_en_gated", 32'(pe_viol), 32'd0);
    check_val("final_drop_count", 32'(drop_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
    $finish;
  end

endmodule
